alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Multi-cycle initiator for the register_bank / mux / alu datapath. It accepts one micro-op per valid/ready handshake and drives the register-bank read ports, mux_sel, the immediate and alu sel. It captures the ALU result, writes it back through the bank write port, and returns a response. It is the active master of the datapath.

Parameters:
AWIDTH, 3, register address width (2**AWIDTH registers, register 0 hardwired to zero in the bank)
DWIDTH, 8, data width
SWIDTH, 3, ALU select width

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
op_valid  input  1  micro-op offered
op_ready  output  1  sequencer can accept
op_alu_sel  input  SWIDTH  operation: AND=0, OR=1, ADD=2, SUB=6, SLT=7
op_use_imm  input  1  1: src2 = op_imm; 0: src2 = register rs2
op_rs1  input  AWIDTH  source register 1
op_rs2  input  AWIDTH  source register 2
op_rd  input  AWIDTH  destination register
op_imm  input  DWIDTH  immediate
rf_raddr1  output  AWIDTH  to bank raddr1
rf_raddr2  output  AWIDTH  to bank raddr2
rf_waddr  output  AWIDTH  to bank waddr
rf_wdata  output  DWIDTH  to bank wdata
rf_wen  output  1  to bank wen
mux_sel  output  1  to src2 mux; 1 selects the constant
imm_out  output  DWIDTH  to mux constant input
alu_sel  output  SWIDTH  to alu sel
alu_res  input  DWIDTH  from alu res
alu_res_is_0  input  1  from alu res_is_0
rsp_valid  output  1  response valid
rsp_data  output  DWIDTH  result
rsp_zero  output  1  result is zero
rsp_err  output  1  illegal op_alu_sel

Behaviour:
- States: IDLE, EXEC, WB. All outputs are registered or decoded from state plus latched op registers.
- Reset (rst_n low at a clk edge): state=IDLE. All latched fields are 0, so every address, alu_sel, mux_sel and imm_out output is 0. rf_wen=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0. op_ready=1 from the first cycle after reset.
- IDLE: op_ready=1. On op_valid && op_ready at an edge, latch all op_* fields and go to EXEC.
- EXEC (1 cycle):
  - op_ready=0.
  - rf_raddr1=rs1, rf_raddr2=rs2, alu_sel=sel, mux_sel=use_imm, imm_out=imm.
  - Bank read is combinational. At the closing edge, capture alu_res into result, alu_res_is_0 into zero, and the illegal-sel flag. Go to WB.
- WB (1 cycle):
  - rf_waddr=rd, rf_wdata=result.
  - rf_wen=1 only if rd!=0 and the sel is legal.
  - rsp_valid=1 for exactly this cycle, with rsp_data/rsp_zero/rsp_err.
  - Go to IDLE.
- Latency: accept edge E0, response and write cycle between E1 and E2. Throughput is one op per 3 cycles. op_valid held high issues back-to-back ops 3 cycles apart.
- Illegal sel (not 0,1,2,6,7): result forced to 0, rsp_zero=1, rsp_err=1, no write.
- Read ports hold the last latched addresses outside EXEC. rf_wen is never high outside WB.
- Reset mid-operation (EXEC or WB): abort, no write occurs from that edge onward, return to IDLE.
- Arithmetic is owned by the ALU. Results wrap modulo 2**DWIDTH. SLT is unsigned.

Optional Feature:
- Macro: ALU_SEQ_RSP_HOLD_EN.
- Defined:
  - Adds input rsp_ready (1 bit) and a RSP state after WB.
  - The write still happens for exactly one cycle in WB.
  - rsp_valid rises in WB and stays high, with data stable, until rsp_valid && rsp_ready at an edge. The FSM then returns to IDLE.
  - If rsp_ready is already high in WB, WB goes directly to IDLE, so there is no extra latency.
- Not defined: no rsp_ready port and rsp_valid is a one-cycle pulse.

Decomposition:
- Package alu_pkg holds:
  - sel_t
  - the localparams AND/OR/ADD/SUB/SLT
  - the state enum type seq_state_t (IDLE, EXEC, WB, RSP)
  - the function sel_is_legal()
- The testbench and the ALU import the same constants.
- No sub-module is natural; the FSM and op registers stay flat.

Test Plan:
- Reset held 2 cycles with op_valid=1 -> op_ready=1, rf_wen=0, rsp_valid=0, all addresses 0; no op accepted while rst_n=0.
- ADD, use_imm=1, rs1=0, imm=0x25, rd=3 -> WB cycle shows rf_wen=1, rf_waddr=3, rf_wdata=0x25, rsp_data=0x25, rsp_zero=0.
- SUB, rs1=3, rs2=3, rd=4 -> rsp_data=0x00, rsp_zero=1, write to r4 of 0x00.
- OR, rs1=3, imm=0x5A, rd=0 -> rsp_data=0x7F, rf_wen stays 0 throughout.
- op_alu_sel=3 -> rsp_err=1, rsp_data=0, no write. Then SLT with r3 (0x25) and imm=0x30 -> rsp_data=0x01.
- op_valid held high for two ADDs -> second accepted exactly 3 cycles after the first, and op_ready=0 in EXEC/WB. A third op with rst_n pulsed low in EXEC -> no rf_wen, FSM in IDLE the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes, sequencer state encoding and the legal-select check.
// Imported by the sequencer, the ALU and the testbench.
package alu_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t AND = 3'd0;
    localparam sel_t OR  = 3'd1;
    localparam sel_t ADD = 3'd2;
    localparam sel_t SUB = 3'd6;
    localparam sel_t SLT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        RSP  = 2'd3
    } seq_state_t;

    function automatic logic sel_is_legal(input sel_t sel);
        return (sel == AND) || (sel == OR) || (sel == ADD) ||
               (sel == SUB) || (sel == SLT);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle micro-op initiator for the register bank / src2 mux / ALU datapath.
// Optional macro ALU_SEQ_RSP_HOLD_EN adds rsp_ready and holds the response until taken.
//
// state | meaning
// IDLE  | ready for a micro-op; read ports hold last latched addresses
// EXEC  | datapath driven from latched op; ALU result captured at closing edge
// WB    | bank write (legal sel, rd != 0) and response valid
// RSP   | response held until rsp_ready (only with ALU_SEQ_RSP_HOLD_EN)
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8,
    parameter int SWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [SWIDTH-1:0] op_alu_sel,
    input  logic              op_use_imm,
    input  logic [AWIDTH-1:0] op_rs1,
    input  logic [AWIDTH-1:0] op_rs2,
    input  logic [AWIDTH-1:0] op_rd,
    input  logic [DWIDTH-1:0] op_imm,
    output logic [AWIDTH-1:0] rf_raddr1,
    output logic [AWIDTH-1:0] rf_raddr2,
    output logic [AWIDTH-1:0] rf_waddr,
    output logic [DWIDTH-1:0] rf_wdata,
    output logic              rf_wen,
    output logic              mux_sel,
    output logic [DWIDTH-1:0] imm_out,
    output logic [SWIDTH-1:0] alu_sel,
    input  logic [DWIDTH-1:0] alu_res,
    input  logic              alu_res_is_0,
`ifdef ALU_SEQ_RSP_HOLD_EN
    input  logic              rsp_ready,
`endif
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);

    seq_state_t state_q, state_d;

    logic [SWIDTH-1:0] sel_q;
    logic              use_imm_q;
    logic [AWIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [DWIDTH-1:0] imm_q;
    logic [DWIDTH-1:0] result_q;
    logic              zero_q;
    logic              err_q;
    logic              sel_legal;

    assign sel_legal = sel_is_legal(sel_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            use_imm_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && op_valid) begin
                sel_q     <= op_alu_sel;
                use_imm_q <= op_use_imm;
                rs1_q     <= op_rs1;
                rs2_q     <= op_rs2;
                rd_q      <= op_rd;
                imm_q     <= op_imm;
            end
            // Illegal selects report a forced zero result regardless of the ALU output
            if (state_q == EXEC) begin
                result_q <= sel_legal ? alu_res : '0;
                zero_q   <= sel_legal ? alu_res_is_0 : 1'b1;
                err_q    <= !sel_legal;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_ready  = 1'b0;
        rf_wen    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                rf_wen    = (rd_q != '0) && !err_q;
                rsp_valid = 1'b1;
`ifdef ALU_SEQ_RSP_HOLD_EN
                state_d   = rsp_ready ? IDLE : RSP;
`else
                state_d   = IDLE;
`endif
            end
`ifdef ALU_SEQ_RSP_HOLD_EN
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign rf_raddr1 = rs1_q;
    assign rf_raddr2 = rs2_q;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = result_q;
    assign mux_sel   = use_imm_q;
    assign imm_out   = imm_q;
    assign alu_sel   = sel_q;
    assign rsp_data  = result_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;

endmodule
